lc3_decode_stage: RTL

//  LC3 pipeline decode stage. Sits between fetch/instruction memory and execute.
//  - Captures Instr_dout and npc_in when enable_decode is high.
//  - Produces the registered IR, npc_out and the execute/writeback/memory control words.
//  - Same input signals as the decode_in agent, so the decode_in monitor observes this block's inputs.

---
 rtl/lc3_decode_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/lc3_decode_stage.sv
// LC3 pipeline decode stage: registers the fetched instruction and its npc, and
// derives the execute, writeback and memory control words from the opcode.
module lc3_decode_stage #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_decode,
  input  logic [INSTR_W-1:0] Instr_dout,
  input  logic [ADDR_W-1:0]  npc_in,
  output logic [INSTR_W-1:0] IR,
  output logic [ADDR_W-1:0]  npc_out,
  output logic [5:0]         E_Control,
  output logic [1:0]         W_Control,
  output logic               Mem_Control,
  output logic               decode_valid,
  output logic               illegal_op
);

  typedef enum logic [3:0] {
    OP_BR   = 4'h0, OP_ADD = 4'h1, OP_LD   = 4'h2, OP_ST   = 4'h3,
    OP_JSR  = 4'h4, OP_AND = 4'h5, OP_LDR  = 4'h6, OP_STR  = 4'h7,
    OP_RTI  = 4'h8, OP_NOT = 4'h9, OP_LDI  = 4'hA, OP_STI  = 4'hB,
    OP_JMP  = 4'hC, OP_RES = 4'hD, OP_LEA  = 4'hE, OP_TRAP = 4'hF
  } opcode_e;

  // pcselect1 base-offset selects and writeback sources
  localparam logic [1:0] PC1_OFF11 = 2'b00;
  localparam logic [1:0] PC1_OFF9  = 2'b01;
  localparam logic [1:0] PC1_OFF6  = 2'b10;
  localparam logic [1:0] PC1_ZERO  = 2'b11;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  opcode_e    opcode;
  logic [1:0] alu_control;
  logic [1:0] pcselect1;
  logic       pcselect2;
  logic       op2select;
  logic [1:0] w_control_d;
  logic       mem_control_d;
  logic       illegal_d;

  assign opcode = opcode_e'(Instr_dout[INSTR_W-1 -: 4]);

  // NOTE: every combinational output gets a default before the case so no
  // opcode path can leave a signal unassigned and infer a latch.
  always_comb begin
    alu_control   = 2'b00;
    pcselect1     = PC1_OFF11;
    pcselect2     = 1'b0;
    op2select     = 1'b0;
    w_control_d   = WB_ALU;
    mem_control_d = 1'b0;
    illegal_d     = 1'b0;
    unique case (opcode)
      OP_ADD: op2select = ~Instr_dout[5];
      OP_AND: begin alu_control = 2'b01; op2select = ~Instr_dout[5]; end
      OP_NOT: begin alu_control = 2'b10; op2select = 1'b1; end
      OP_BR, OP_ST: begin pcselect1 = PC1_OFF9; pcselect2 = 1'b1; end
      OP_JMP: pcselect1 = PC1_ZERO;
      OP_LD:  begin pcselect1 = PC1_OFF9; pcselect2 = 1'b1; w_control_d = WB_MEM; end
      OP_LDI: begin
        pcselect1 = PC1_OFF9; pcselect2 = 1'b1; w_control_d = WB_MEM; mem_control_d = 1'b1;
      end
      OP_STI: begin pcselect1 = PC1_OFF9; pcselect2 = 1'b1; mem_control_d = 1'b1; end
      OP_LEA: begin pcselect1 = PC1_OFF9; pcselect2 = 1'b1; w_control_d = WB_PC; end
      OP_LDR: begin pcselect1 = PC1_OFF6; w_control_d = WB_MEM; end
      OP_STR: pcselect1 = PC1_OFF6;
      OP_JSR, OP_RTI, OP_RES, OP_TRAP: illegal_d = 1'b1;
      default: illegal_d = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IR           <= '0;
      npc_out      <= '0;
      E_Control    <= '0;
      W_Control    <= '0;
      Mem_Control  <= 1'b0;
      decode_valid <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      decode_valid <= enable_decode;
      if (enable_decode) begin
        IR          <= Instr_dout;
        npc_out     <= npc_in;
        E_Control   <= {alu_control, pcselect1, pcselect2, op2select};
        W_Control   <= w_control_d;
        Mem_Control <= mem_control_d;
        illegal_op  <= illegal_d;
      end
    end
  end

endmodule
